reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_reset_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Always-on reset sequencer. It asserts every downstream domain reset together
//   and waits until all domains acknowledge. It holds them for HOLD_CYCLES, then
//   releases them one at a time in ascending index order. Each release waits
//   for that domain's acknowledge, plus an optional GAP_CYCLES pause before the
//   next release.
//
//   Optional feature: define RESET_SEQ_TIMEOUT_EN to bound each ack wait to
//   TIMEOUT_CYCLES. On expiry err_o is set (sticky) and the sequence proceeds.
//   Without the macro the waits are unbounded and err_o stays 0.
//
// Ports
//   clk_i   sequencer clock
//   rst_i   asynchronous active-high reset; restarts the sequence
//   req_i   software reset request (single-cycle pulse, honoured only in IDLE)
//   ack_i   per-domain "in reset" level, already synchronized to clk_i
//   rst_o   per-domain reset request, active-high
//   busy_o  sequence in progress
//   done_o  last sequence completed with all domains released
//   err_o   sticky ack-timeout flag
module reset_sequencer #(
  parameter int unsigned NUM_DOMAINS    = 3,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  input  logic [NUM_DOMAINS-1:0] ack_i,
  output logic [NUM_DOMAINS-1:0] rst_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX) + 1;
  localparam int unsigned KW      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = (GAP_CYCLES == 0) ? '0 : CW'(GAP_CYCLES - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(NUM_DOMAINS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ASSERT,
    S_HOLD,
    S_RELEASE,
    S_WAIT_REL,
    S_GAP
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [KW-1:0]          r_k, w_k_nxt, w_k_inc;
  logic [NUM_DOMAINS-1:0] r_rst, w_rst_nxt;
  logic                   r_busy, r_done, w_done_nxt, r_err, w_err_nxt;
  logic                   w_timeout;

`ifdef RESET_SEQ_TIMEOUT_EN
  localparam int unsigned   TW      = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_wait;
  logic          w_waiting;

  assign w_waiting = (r_state == S_WAIT_ASSERT) || (r_state == S_WAIT_REL);
  assign w_timeout = w_waiting && (r_wait == TO_LAST);

  // Restarts on every state change; expiry forces a state change, so it never wraps.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wait <= '0;
    end else if (w_state_nxt != r_state) begin
      r_wait <= '0;
    end else if (w_waiting) begin
      r_wait <= r_wait + 1'b1;
    end
  end
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  assign w_k_inc = r_k + 1'b1;

  // rst_o[k] is cleared on the transition into RELEASE, so the registered
  // output is already low during the RELEASE cycle itself.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_k_nxt     = r_k;
    w_rst_nxt   = r_rst;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;
    unique case (r_state)
      S_IDLE: begin
        if (req_i) begin
          w_rst_nxt   = '1;
          w_done_nxt  = 1'b0;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_WAIT_ASSERT;
        end
      end
      S_WAIT_ASSERT: begin
        if ((&ack_i) || w_timeout) begin
          if (!(&ack_i)) w_err_nxt = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_cnt_nxt    = '0;
          w_k_nxt      = '0;
          w_rst_nxt[0] = 1'b0;
          w_state_nxt  = S_RELEASE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RELEASE: begin
        w_state_nxt = S_WAIT_REL;
      end
      S_WAIT_REL: begin
        if (!ack_i[r_k] || w_timeout) begin
          if (ack_i[r_k]) w_err_nxt = 1'b1;
          if (r_k == K_LAST) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (GAP_CYCLES == 0) begin
            w_k_nxt            = w_k_inc;
            w_rst_nxt[w_k_inc] = 1'b0;
            w_state_nxt        = S_RELEASE;
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_nxt          = '0;
          w_k_nxt            = w_k_inc;
          w_rst_nxt[w_k_inc] = 1'b0;
          w_state_nxt        = S_RELEASE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_WAIT_ASSERT;
      r_cnt   <= '0;
      r_k     <= '0;
      r_rst   <= '1;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_k     <= w_k_nxt;
      r_rst   <= w_rst_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign rst_o  = r_rst;
  assign busy_o = r_busy;
  assign done_o = r_done;
  assign err_o  = r_err;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer.
// u_dut   : default parameters, ack model = ack follows rst_o (rise after 1 cycle
//           once seen with rst_i low, fall 3 cycles after rst_o falls).
// u_dut_g0: GAP_CYCLES = 0 with ack wired straight to rst_o.
// Every output bundle {rst_o, busy_o, done_o, err_o} change is popped against
// an expected (cycle, value) entry; cyc counts posedges and is read at negedges.
module tb_reset_sequencer;
  localparam int unsigned N = 3;
`ifdef RESET_SEQ_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 8;
`else
  localparam int unsigned TB_TIMEOUT = 1024;
`endif
  localparam int unsigned D_RISE = 1;
  localparam int unsigned D_FALL = 3;

  logic         clk;
  logic         rst_i, req_i, req_g0;
  logic [N-1:0] ack_i, ack_g0;
  logic [N-1:0] rst_o, rst_g0;
  logic         busy_o, done_o, err_o, busy_g0, done_g0, err_g0;

  typedef struct {
    int unsigned cyc;
    logic [5:0]  v;
  } ev_t;

  ev_t          q_a[$];
  ev_t          q_b[$];
  int unsigned  cyc = 0;
  int           total = 0;
  int           bad = 0;
  logic [N-1:0] stuck, pend;
  int unsigned  since[N];

  reset_sequencer #(.NUM_DOMAINS(N), .HOLD_CYCLES(16), .GAP_CYCLES(4),
                    .TIMEOUT_CYCLES(TB_TIMEOUT)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .ack_i(ack_i),
    .rst_o(rst_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  reset_sequencer #(.NUM_DOMAINS(N), .HOLD_CYCLES(16), .GAP_CYCLES(0),
                    .TIMEOUT_CYCLES(TB_TIMEOUT)) u_dut_g0 (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_g0), .ack_i(ack_g0),
    .rst_o(rst_g0), .busy_o(busy_g0), .done_o(done_g0), .err_o(err_g0)
  );

  always_comb ack_g0 = rst_g0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_a(input int unsigned c, input logic [2:0] r, input logic b,
                        input logic d, input logic e);
    ev_t x;
    x.cyc = c; x.v = {r, b, d, e};
    q_a.push_back(x);
  endtask

  task automatic push_b(input int unsigned c, input logic [2:0] r, input logic b,
                        input logic d, input logic e);
    ev_t x;
    x.cyc = c; x.v = {r, b, d, e};
    q_b.push_back(x);
  endtask

  // Main DUT sequence once ack_i reads 111 at posedge base+3:
  // HOLD for 16, then releases 8 apart (3 ack delay + 1 sample + 4 gap).
  task automatic seq_a(input int unsigned base);
    push_a(base + 19, 3'b110, 1'b1, 1'b0, 1'b0);
    push_a(base + 27, 3'b100, 1'b1, 1'b0, 1'b0);
    push_a(base + 35, 3'b000, 1'b1, 1'b0, 1'b0);
    push_a(base + 39, 3'b000, 1'b0, 1'b1, 1'b0);
  endtask

  // Zero-gap DUT with immediate acks: HOLD entered at base+1, releases 2 apart.
  task automatic seq_b(input int unsigned base);
    push_b(base + 17, 3'b110, 1'b1, 1'b0, 1'b0);
    push_b(base + 19, 3'b100, 1'b1, 1'b0, 1'b0);
    push_b(base + 21, 3'b000, 1'b1, 1'b0, 1'b0);
    push_b(base + 23, 3'b000, 1'b0, 1'b1, 1'b0);
  endtask

  // One cycle of stimulus; also advances the domain ack model of u_dut.
  task automatic tick();
    @(negedge clk);
    for (int j = 0; j < N; j++) begin
      if (stuck[j]) begin
        ack_i[j] = 1'b1;
        pend[j]  = 1'b0;
      end else if (rst_i) begin
        pend[j] = 1'b0;
      end else if (ack_i[j] != rst_o[j]) begin
        if (!pend[j]) begin
          pend[j]  = 1'b1;
          since[j] = cyc;
        end
        if (cyc - since[j] >= (rst_o[j] ? D_RISE : D_FALL)) begin
          ack_i[j] = rst_o[j];
          pend[j]  = 1'b0;
        end
      end else begin
        pend[j] = 1'b0;
      end
    end
  endtask

  task automatic drain(input int unsigned limit);
    int unsigned n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < limit) begin
      tick();
      n++;
    end
    if (q_a.size() != 0 || q_b.size() != 0) begin
      chk("drain_timeout", q_a.size() + q_b.size(), 0);
      q_a.delete();
      q_b.delete();
    end
  endtask

  initial begin : mon_a
    logic [5:0] prev, cur;
    bit         seen;
    ev_t        e;
    seen = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {rst_o, busy_o, done_o, err_o};
      if (!seen || cur !== prev) begin
        if (q_a.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mon_a_unexpected: got %b at cyc %0d, nothing expected", cur, cyc);
        end else begin
          e = q_a.pop_front();
          chk("mon_a_value", 32'(cur), 32'(e.v));
          chk("mon_a_cycle", cyc, e.cyc);
        end
      end
      prev = cur;
      seen = 1'b1;
    end
  end

  initial begin : mon_b
    logic [5:0] prev, cur;
    bit         seen;
    ev_t        e;
    seen = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {rst_g0, busy_g0, done_g0, err_g0};
      if (!seen || cur !== prev) begin
        if (q_b.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mon_b_unexpected: got %b at cyc %0d, nothing expected", cur, cyc);
        end else begin
          e = q_b.pop_front();
          chk("mon_b_value", 32'(cur), 32'(e.v));
          chk("mon_b_cycle", cyc, e.cyc);
        end
      end
      prev = cur;
      seen = 1'b1;
    end
  end

  initial begin : watchdog
    #400000;
    bad++;
    $display("FAIL watchdog: run exceeded time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned c0, q, r, s;
`ifdef RESET_SEQ_TIMEOUT_EN
    int unsigned t;
`endif
    rst_i  = 1'b0;
    req_i  = 1'b0;
    req_g0 = 1'b0;
    ack_i  = '0;
    stuck  = '0;
    pend   = '0;
    for (int j = 0; j < N; j++) since[j] = 0;

    // Power-on: reset values visible at the first negedge.
    push_a(1, 3'b111, 1'b1, 1'b0, 1'b0);
    push_b(1, 3'b111, 1'b1, 1'b0, 1'b0);
    #1 rst_i = 1'b1;
    repeat (3) tick();
    c0 = cyc;
    rst_i = 1'b0;
    seq_a(c0);
    seq_b(c0);
    drain(100);

    // Software request from IDLE; a second pulse in HOLD must not disturb timing.
    repeat (3) tick();
    q = cyc;
    req_i = 1'b1;
    push_a(q + 1, 3'b111, 1'b1, 1'b0, 1'b0);
    seq_a(q);
    tick();
    req_i = 1'b0;
    while (cyc < q + 10) tick();
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    drain(100);

    // rst_i while WAIT_REL with k = 1 (rst_o = 100): outputs go 111 before any edge.
    repeat (3) tick();
    r = cyc;
    req_i = 1'b1;
    push_a(r + 1,  3'b111, 1'b1, 1'b0, 1'b0);
    push_a(r + 19, 3'b110, 1'b1, 1'b0, 1'b0);
    push_a(r + 27, 3'b100, 1'b1, 1'b0, 1'b0);
    tick();
    req_i = 1'b0;
    while (cyc < r + 28) tick();
    @(posedge clk);
    #1 rst_i = 1'b1;
    push_a(r + 29, 3'b111, 1'b1, 1'b0, 1'b0);
    push_b(r + 29, 3'b111, 1'b1, 1'b0, 1'b0);
    tick();
    c0 = cyc;
    rst_i = 1'b0;
    seq_a(c0);
    seq_b(c0);
    drain(100);

    // ack_i[1] stuck high.
    repeat (3) tick();
    s = cyc;
    stuck[1] = 1'b1;
    ack_i[1] = 1'b1;
    req_i = 1'b1;
    push_a(s + 1,  3'b111, 1'b1, 1'b0, 1'b0);
    push_a(s + 19, 3'b110, 1'b1, 1'b0, 1'b0);
    push_a(s + 27, 3'b100, 1'b1, 1'b0, 1'b0);
`ifdef RESET_SEQ_TIMEOUT_EN
    // 8 cycles in WAIT_REL (s+28..s+35), timeout edge s+36, gap of 4, last ack.
    push_a(s + 36, 3'b100, 1'b1, 1'b0, 1'b1);
    push_a(s + 40, 3'b000, 1'b1, 1'b0, 1'b1);
    push_a(s + 44, 3'b000, 1'b0, 1'b1, 1'b1);
    tick();
    req_i = 1'b0;
    drain(100);
    stuck[1] = 1'b0;
    repeat (5) tick();
    t = cyc;
    req_i = 1'b1;
    push_a(t + 1, 3'b111, 1'b1, 1'b0, 1'b0);
    seq_a(t);
    tick();
    req_i = 1'b0;
    drain(100);
`else
    tick();
    req_i = 1'b0;
    drain(100);
    repeat (2000) tick();
    chk("stall_outputs", 32'({rst_o, busy_o, done_o, err_o}), 32'(6'b100100));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
